// File: rtl/cache_ctrl_param_pkg.sv
// ============================================================================
// Module  : cache_ctrl_param_pkg
// Brief   : Shared state encoding, write-mode constants and helpers for the
//           parametrised cache controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_ctrl_param_pkg;

  // Controller state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_MEM_READ  = 3'd1;
  localparam logic [2:0] ST_MEM_WRITE = 3'd2;
  localparam logic [2:0] ST_RESP      = 3'd3;
  localparam logic [2:0] ST_CACHE_UPD = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_MEM_READ  = ST_MEM_READ,
    S_MEM_WRITE = ST_MEM_WRITE,
    S_RESP      = ST_RESP,
    S_CACHE_UPD = ST_CACHE_UPD
  } state_e;

  // What a store does to the cached copy once it is in SRAM
  localparam int WM_INVALIDATE = 0;
  localparam int WM_UPDATE     = 1;

  localparam logic ONE  = 1'b1;
  localparam logic ZERO = 1'b0;

  // Width of the word-select field; a one-word block still gets a 1-bit port
  function automatic int sel_width(input int wpb);
    return (wpb > 1) ? $clog2(wpb) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_ctrl_param_sat.sv
// ============================================================================
// Module  : sat_counter
// Brief   : W-bit event counter that sticks at all-ones instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Count up on each inc_i pulse until the all-ones ceiling is reached
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/cache_ctrl_param.sv
// ============================================================================
// Module  : cache_ctrl_param
// Brief   : Cache controller between the memory stage and the SRAM controller.
//           Zero-wait read hits, block fill on read miss, write-through stores
//           with selectable invalidate/update of the cached copy, and
//           saturating hit/miss counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_ctrl_param
  import cache_ctrl_param_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_BLOCK = 2,
  parameter int CACHE_ADDR_W    = 17,
  parameter int WRITE_MODE      = WM_INVALIDATE,
  parameter int CNT_W           = 16,
  localparam int BLK_W          = DATA_W * WORDS_PER_BLOCK,
  localparam int WSEL_W         = sel_width(WORDS_PER_BLOCK)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // CPU side
  input  logic                    read_en_i,
  input  logic                    write_en_i,
  input  logic [ADDR_W-1:0]       address_i,
  input  logic [DATA_W-1:0]       write_data_i,
  output logic [DATA_W-1:0]       read_data_o,
  output logic                    ready_o,
  // SRAM controller side
  output logic [ADDR_W-1:0]       sram_address_o,
  output logic [DATA_W-1:0]       sram_write_data_o,
  output logic                    sram_read_en_o,
  output logic                    sram_write_en_o,
  input  logic                    sram_ready_i,
  input  logic [BLK_W-1:0]        sram_read_data_i,
  // Cache array side
  output logic [CACHE_ADDR_W-1:0] cache_address_o,
  output logic                    cache_read_en_o,
  input  logic                    cache_hit_i,
  input  logic [DATA_W-1:0]       cache_read_data_i,
  output logic                    cache_write_en_o,
  output logic [BLK_W-1:0]        cache_write_data_o,
  output logic                    cache_word_write_en_o,
  output logic [WSEL_W-1:0]       cache_word_sel_o,
  output logic [DATA_W-1:0]       cache_word_data_o,
  output logic                    cache_invalidation_o,
  // Performance counters
  output logic [CNT_W-1:0]        hit_count_o,
  output logic [CNT_W-1:0]        miss_count_o
);

  // Byte-offset bits below the word index
  localparam int BOFF = $clog2(DATA_W / 8);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] read_data_q;
  logic              hit_q;
  logic              sram_read_en_q;
  logic              sram_write_en_q;
  logic              cache_inval_q;
  logic              cache_word_we_q;

  logic              in_idle;
  logic              rd_req;
  logic              wr_req;
  logic              any_req;
  logic              idle_hit;
  logic              idle_miss;
  logic              fill_done;
  logic [DATA_W-1:0] fill_word;

  // Requests only count in IDLE and never while reset is asserted, so every
  // enable and the hit path are forced low the moment rst_ni falls.
  assign in_idle   = (state_q == S_IDLE) && rst_ni;
  assign rd_req    = in_idle && read_en_i;
  assign wr_req    = in_idle && write_en_i && !read_en_i;
  assign any_req   = in_idle && (read_en_i || write_en_i);
  assign idle_hit  = rd_req && cache_hit_i;
  assign idle_miss = rd_req && !cache_hit_i;
  assign fill_done = (state_q == S_MEM_READ) && sram_ready_i;

  // The cache sees the live CPU address in IDLE and the latched one afterwards
  assign cache_address_o = (state_q == S_IDLE) ? address_i[BOFF +: CACHE_ADDR_W]
                                               : addr_q[BOFF +: CACHE_ADDR_W];

  generate
    if (WORDS_PER_BLOCK > 1) begin : g_wsel
      logic [DATA_W-1:0] blk_words [WORDS_PER_BLOCK];

      assign cache_word_sel_o = (state_q == S_IDLE) ? address_i[BOFF +: WSEL_W]
                                                    : addr_q[BOFF +: WSEL_W];

      for (genvar g = 0; g < WORDS_PER_BLOCK; g++) begin : g_blk_word
        assign blk_words[g] = sram_read_data_i[g*DATA_W +: DATA_W];
      end

      assign fill_word = blk_words[cache_word_sel_o];
    end else begin : g_wsel_single
      assign cache_word_sel_o = '0;
      assign fill_word        = sram_read_data_i[DATA_W-1:0];
    end
  endgenerate

  // Next-state selection; read_en wins over write_en in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (idle_miss) begin
          state_d = S_MEM_READ;
        end else if (wr_req) begin
          state_d = S_MEM_WRITE;
        end
      end
      S_MEM_READ: begin
        if (sram_ready_i) state_d = S_RESP;
      end
      S_MEM_WRITE: begin
        if (sram_ready_i) state_d = S_CACHE_UPD;
      end
      S_RESP:      state_d = S_IDLE;
      S_CACHE_UPD: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // State register with Moore enables registered from the next state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      sram_read_en_q  <= ZERO;
      sram_write_en_q <= ZERO;
      cache_inval_q   <= ZERO;
      cache_word_we_q <= ZERO;
    end else begin
      state_q         <= state_d;
      sram_read_en_q  <= (state_d == S_MEM_READ);
      sram_write_en_q <= (state_d == S_MEM_WRITE);
      cache_inval_q   <= (state_d == S_CACHE_UPD) && (WRITE_MODE == WM_INVALIDATE);
      // No write-allocate: only a line that hit at request time is patched
      cache_word_we_q <= (state_d == S_CACHE_UPD) && (WRITE_MODE == WM_UPDATE) && hit_q;
    end
  end

  // Request capture, fill word latch and held CPU read data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      read_data_q <= '0;
      hit_q       <= ZERO;
    end else begin
      if (any_req) begin
        addr_q <= address_i;
        data_q <= write_data_i;
        hit_q  <= cache_hit_i;
      end
      if (fill_done) begin
        rdata_q <= fill_word;
      end
      if (idle_hit) begin
        read_data_q <= cache_read_data_i;
      end else if (state_q == S_RESP) begin
        read_data_q <= rdata_q;
      end
    end
  end

  assign ready_o = !rst_ni
                 || idle_hit
                 || (in_idle && !read_en_i && !write_en_i)
                 || (state_q == S_RESP)
                 || (state_q == S_CACHE_UPD);

  assign read_data_o = idle_hit             ? cache_read_data_i :
                       (state_q == S_RESP)  ? rdata_q           :
                                              read_data_q;

  assign sram_address_o        = addr_q;
  assign sram_write_data_o     = data_q;
  assign sram_read_en_o        = sram_read_en_q;
  assign sram_write_en_o       = sram_write_en_q;

  assign cache_read_en_o       = rd_req;
  assign cache_write_en_o      = fill_done;
  assign cache_write_data_o    = sram_read_data_i;
  assign cache_word_write_en_o = cache_word_we_q;
  assign cache_word_data_o     = data_q;
  assign cache_invalidation_o  = cache_inval_q;

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (idle_hit),
    .count_o (hit_count_o)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (idle_miss),
    .count_o (miss_count_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl_param.sv
// ============================================================================
// Module  : tb_cache_ctrl_param
// Brief   : Directed self-checking bench. Instance A: write-invalidate, two
//           words per block, 2-bit counters. Instance B: write-update, four
//           words per block, 16-bit counters. Both share the CPU-side stimulus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         read_en, write_en;
  logic [31:0]  address, write_data;
  logic         sram_ready;
  logic         cache_hit;
  logic [31:0]  cache_read_data;
  logic [63:0]  srd_a;
  logic [127:0] srd_b;

  logic [31:0]  a_read_data, a_sram_address, a_sram_wdata, a_word_data;
  logic         a_ready, a_sram_re, a_sram_we, a_cache_re, a_cache_we, a_word_we, a_inval;
  logic [16:0]  a_cache_address;
  logic [63:0]  a_cache_wdata;
  logic [0:0]   a_word_sel;
  logic [1:0]   a_hit_cnt, a_miss_cnt;

  logic [31:0]  b_read_data, b_sram_address, b_sram_wdata, b_word_data;
  logic         b_ready, b_sram_re, b_sram_we, b_cache_re, b_cache_we, b_word_we, b_inval;
  logic [16:0]  b_cache_address;
  logic [127:0] b_cache_wdata;
  logic [1:0]   b_word_sel;
  logic [15:0]  b_hit_cnt, b_miss_cnt;

  cache_ctrl_param #(
    .WORDS_PER_BLOCK(2), .WRITE_MODE(0), .CNT_W(2)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .read_en_i(read_en), .write_en_i(write_en), .address_i(address),
    .write_data_i(write_data), .read_data_o(a_read_data), .ready_o(a_ready),
    .sram_address_o(a_sram_address), .sram_write_data_o(a_sram_wdata),
    .sram_read_en_o(a_sram_re), .sram_write_en_o(a_sram_we),
    .sram_ready_i(sram_ready), .sram_read_data_i(srd_a),
    .cache_address_o(a_cache_address), .cache_read_en_o(a_cache_re),
    .cache_hit_i(cache_hit), .cache_read_data_i(cache_read_data),
    .cache_write_en_o(a_cache_we), .cache_write_data_o(a_cache_wdata),
    .cache_word_write_en_o(a_word_we), .cache_word_sel_o(a_word_sel),
    .cache_word_data_o(a_word_data), .cache_invalidation_o(a_inval),
    .hit_count_o(a_hit_cnt), .miss_count_o(a_miss_cnt)
  );

  cache_ctrl_param #(
    .WORDS_PER_BLOCK(4), .WRITE_MODE(1), .CNT_W(16)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .read_en_i(read_en), .write_en_i(write_en), .address_i(address),
    .write_data_i(write_data), .read_data_o(b_read_data), .ready_o(b_ready),
    .sram_address_o(b_sram_address), .sram_write_data_o(b_sram_wdata),
    .sram_read_en_o(b_sram_re), .sram_write_en_o(b_sram_we),
    .sram_ready_i(sram_ready), .sram_read_data_i(srd_b),
    .cache_address_o(b_cache_address), .cache_read_en_o(b_cache_re),
    .cache_hit_i(cache_hit), .cache_read_data_i(cache_read_data),
    .cache_write_en_o(b_cache_we), .cache_write_data_o(b_cache_wdata),
    .cache_word_write_en_o(b_word_we), .cache_word_sel_o(b_word_sel),
    .cache_word_data_o(b_word_data), .cache_invalidation_o(b_inval),
    .hit_count_o(b_hit_cnt), .miss_count_o(b_miss_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Store transaction with SRAM ready in the third MEM_WRITE cycle
  task automatic do_write(input logic [31:0] addr, input logic [31:0] wd,
                          input logic hit, input logic [1:0] exp_sel);
    int n_low, n_inv, n_wwe;
    tick();
    write_en = 1'b1; address = addr; write_data = wd; cache_hit = hit; sram_ready = 1'b0;
    #3;
    check_eq("wr_idle_ready", a_ready, 0);
    check_eq("wr_idle_swe", a_sram_we, 0);
    n_low = 1; n_inv = 0; n_wwe = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      cache_hit  = 1'b0;
      sram_ready = (i == 3);
      #3;
      check_eq("wr_swe", a_sram_we, 1);
      check_eq("wr_saddr", a_sram_address, addr);
      check_eq("wr_sdata", a_sram_wdata, wd);
      if (!a_ready) n_low++;
      n_inv += int'(a_inval);
      n_wwe += int'(b_word_we);
    end
    tick();
    sram_ready = 1'b0; write_en = 1'b0;
    #3;
    check_eq("upd_ready", a_ready, 1);
    check_eq("upd_swe_off", a_sram_we, 0);
    check_eq("upd_inv_a", a_inval, 1);
    check_eq("upd_inv_b", b_inval, 0);
    check_eq("upd_wwe_b", b_word_we, hit);
    check_eq("upd_wsel_b", b_word_sel, exp_sel);
    check_eq("upd_wdata_b", b_word_data, wd);
    check_eq("upd_wwe_a", a_word_we, 0);
    n_inv += int'(a_inval);
    n_wwe += int'(b_word_we);
    tick();
    #3;
    n_inv += int'(a_inval);
    n_wwe += int'(b_word_we);
    check_eq("wr_ready_low_cycles", n_low, 4);
    check_eq("wr_inv_pulses", n_inv, 1);
    check_eq("wr_wwe_pulses", n_wwe, int'(hit));
  endtask

  initial begin
    int n_low, n_cwe, n_swe;
    rst_n = 1'b0; read_en = 1'b0; write_en = 1'b0; address = '0; write_data = '0;
    sram_ready = 1'b0; cache_hit = 1'b0; cache_read_data = '0; srd_a = '0; srd_b = '0;

    // Reset: a pending miss request must not wake anything up
    repeat (2) @(posedge clk);
    #1;
    read_en = 1'b1; address = 32'h104;
    #3;
    check_eq("rst_ready", a_ready, 1);
    check_eq("rst_cache_re", a_cache_re, 0);
    check_eq("rst_sram_re", a_sram_re, 0);
    check_eq("rst_read_data", a_read_data, 0);
    check_eq("rst_hit_cnt", a_hit_cnt, 0);
    check_eq("rst_miss_cnt", a_miss_cnt, 0);
    tick();
    read_en = 1'b0; rst_n = 1'b1;
    #3;
    check_eq("idle_ready", a_ready, 1);

    // Read hit at 0x104
    tick();
    read_en = 1'b1; address = 32'h104; cache_hit = 1'b1; cache_read_data = 32'hDEADBEEF;
    #3;
    check_eq("hit_ready", a_ready, 1);
    check_eq("hit_rdata", a_read_data, 32'hDEADBEEF);
    check_eq("hit_cache_re", a_cache_re, 1);
    check_eq("hit_cache_addr", a_cache_address, 17'h41);
    tick();
    read_en = 1'b0; cache_hit = 1'b0; cache_read_data = '0;
    #3;
    check_eq("hit_cnt", a_hit_cnt, 1);
    check_eq("hit_rdata_hold", a_read_data, 32'hDEADBEEF);

    // Read miss at 0x104, SRAM ready in the third MEM_READ cycle
    tick();
    read_en = 1'b1; address = 32'h104; cache_hit = 1'b0;
    srd_a = 64'h11112222_33334444;
    srd_b = 128'h44444444_33333333_22222222_11111111;
    #3;
    check_eq("miss_idle_ready", a_ready, 0);
    n_low = 1; n_cwe = int'(a_cache_we);
    for (int i = 1; i <= 3; i++) begin
      tick();
      sram_ready = (i == 3);
      #3;
      check_eq("miss_sram_re", a_sram_re, 1);
      check_eq("miss_sram_addr", a_sram_address, 32'h104);
      if (!a_ready) n_low++;
      n_cwe += int'(a_cache_we);
    end
    check_eq("miss_fill_data", a_cache_wdata, 64'h11112222_33334444);
    tick();
    sram_ready = 1'b0; read_en = 1'b0;
    #3;
    n_cwe += int'(a_cache_we);
    check_eq("resp_ready", a_ready, 1);
    check_eq("resp_rdata_a", a_read_data, 32'h11112222);
    check_eq("resp_rdata_b", b_read_data, 32'h22222222);
    check_eq("resp_sram_re", a_sram_re, 0);
    check_eq("miss_ready_low_cycles", n_low, 4);
    check_eq("miss_cwe_pulses", n_cwe, 1);
    check_eq("miss_cnt", a_miss_cnt, 1);
    tick();
    #3;
    check_eq("miss_rdata_hold", a_read_data, 32'h11112222);

    // Reset asserted while a fill is pending with sram_ready high
    tick();
    read_en = 1'b1; address = 32'h200; cache_hit = 1'b0;
    #3;
    tick();
    #3;
    check_eq("mr_sram_re", a_sram_re, 1);
    sram_ready = 1'b1;
    #1;
    check_eq("mr_cache_we", a_cache_we, 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_sram_re", a_sram_re, 0);
    check_eq("arst_cache_we", a_cache_we, 0);
    check_eq("arst_cache_re", a_cache_re, 0);
    check_eq("arst_ready", a_ready, 1);
    check_eq("arst_hit_cnt", a_hit_cnt, 0);
    check_eq("arst_miss_cnt", a_miss_cnt, 0);
    check_eq("arst_read_data", a_read_data, 0);
    read_en = 1'b0; sram_ready = 1'b0;
    tick();
    rst_n = 1'b1;

    // Stores: invalidate in A, update on hit / nothing on miss in B
    do_write(32'h10, 32'hCAFEF00D, 1'b1, 2'd0);
    do_write(32'h0C, 32'h12345678, 1'b1, 2'd3);
    do_write(32'h0C, 32'h0BADCAFE, 1'b0, 2'd3);

    // Simultaneous read/write held for five hit cycles
    tick();
    read_en = 1'b1; write_en = 1'b1; cache_hit = 1'b1; address = 32'h40;
    cache_read_data = 32'hA5A5_5A5A;
    n_swe = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #3;
      check_eq("rw_ready", a_ready, 1);
      check_eq("rw_rdata", a_read_data, 32'hA5A5_5A5A);
      n_swe += int'(a_sram_we);
    end
    tick();
    read_en = 1'b0; write_en = 1'b0; cache_hit = 1'b0;
    #3;
    n_swe += int'(a_sram_we);
    check_eq("rw_no_sram_we", n_swe, 0);
    check_eq("sat_hit_cnt_a", a_hit_cnt, 3);
    check_eq("hit_cnt_b", b_hit_cnt, 5);
    check_eq("rw_miss_cnt", a_miss_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL timeout: got stalled run expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
